// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the two-port SRAM-like bus arbiter: FSM states, owner ids, size codes.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        SBA_IDLE      = 2'd0,
        SBA_WAIT_ADDR = 2'd1,
        SBA_WAIT_DATA = 2'd2
    } sba_state_e;

    localparam logic SBA_OWN_INST = 1'b0;
    localparam logic SBA_OWN_DATA = 1'b1;

    localparam logic [1:0] SBA_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SBA_SIZE_HALF = 2'd1;
    localparam logic [1:0] SBA_SIZE_WORD = 2'd2;

    function automatic logic [2:0] sba_starve_inc(input logic [2:0] cnt);
        return (cnt == 3'd7) ? cnt : cnt + 3'd1;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between fetch (inst) and load/store (data); data-priority with a fetch starvation guard.
// Request-to-bus and bus-response-to-requester paths are combinational; one transaction outstanding.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    sba_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic [2:0]  starve_q, starve_d;

    logic        sel;
    logic        bus_req;
    logic        grant;
    logic        done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= SBA_IDLE;
            owner_q  <= SBA_OWN_INST;
            starve_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        sel      = owner_q;
        bus_req  = 1'b0;
        grant    = 1'b0;
        done     = 1'b0;
        case (state_q)
            SBA_IDLE: begin
                if (inst_req || data_req) begin
                    // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
                    sel     = (data_req && !(inst_req && starve_q == LIMIT)) ? SBA_OWN_DATA : SBA_OWN_INST;
                    bus_req = 1'b1;
                    owner_d = sel;
                    grant   = mem_addr_ok;
                    state_d = mem_addr_ok ? SBA_WAIT_DATA : SBA_WAIT_ADDR;
                end
            end
            SBA_WAIT_ADDR: begin
                // An owner that withdraws its request simply parks the bus here.
                bus_req = (owner_q == SBA_OWN_DATA) ? data_req : inst_req;
                if (bus_req && mem_addr_ok) begin
                    grant   = 1'b1;
                    state_d = SBA_WAIT_DATA;
                end
            end
            SBA_WAIT_DATA: begin
                if (mem_data_ok) begin
                    done    = 1'b1;
                    state_d = SBA_IDLE;
                end
            end
            default: state_d = SBA_IDLE;
        endcase

        if (grant) begin
            starve_d = (sel == SBA_OWN_DATA && inst_req) ? sba_starve_inc(starve_q) : 3'd0;
        end
    end

    assign mem_req   = resetn & bus_req;
    assign mem_wr    = resetn & ((sel == SBA_OWN_DATA) ? data_wr : inst_wr);
    assign mem_size  = !resetn ? 2'd0  : (sel == SBA_OWN_DATA) ? data_size  : inst_size;
    assign mem_addr  = !resetn ? 32'd0 : (sel == SBA_OWN_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = !resetn ? 32'd0 : (sel == SBA_OWN_DATA) ? data_wdata : inst_wdata;

    assign inst_addr_ok = resetn & grant & (sel == SBA_OWN_INST);
    assign data_addr_ok = resetn & grant & (sel == SBA_OWN_DATA);
    assign inst_data_ok = resetn & done & (owner_q == SBA_OWN_INST);
    assign data_data_ok = resetn & done & (owner_q == SBA_OWN_DATA);
    assign inst_rdata   = resetn ? mem_rdata : 32'd0;
    assign data_rdata   = resetn ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: inputs driven on the falling edge, outputs checked 1ns later.
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = SBA_SIZE_WORD;
        inst_addr = 32'hBFC0_0000; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = SBA_SIZE_WORD;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b0; mem_rdata = 32'hDEAD_BEEF;

        // Reset: everything forced low even with live request and responses.
        next_cycle(); #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        resetn = 1'b1;

        // Single inst read.
        next_cycle();
        inst_req = 1'b1; mem_addr_ok = 1'b1; #1;
        chk("rd_mem_req", 32'(mem_req), 32'd1);
        chk("rd_mem_addr", mem_addr, 32'hBFC0_0000);
        chk("rd_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("rd_data_addr_ok", 32'(data_addr_ok), 32'd0);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; #1;
        chk("rd_c1_mem_req", 32'(mem_req), 32'd0);
        chk("rd_c1_inst_data_ok", 32'(inst_data_ok), 32'd0);
        next_cycle(); #1;
        chk("rd_c2_inst_data_ok", 32'(inst_data_ok), 32'd0);
        next_cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_0001; #1;
        chk("rd_c3_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("rd_c3_inst_rdata", inst_rdata, 32'h3C1D_0001);
        chk("rd_c3_data_data_ok", 32'(data_data_ok), 32'd0);

        // Stray response in IDLE is dropped, and the FSM is still idle afterwards.
        next_cycle();
        mem_data_ok = 1'b1; #1;
        chk("stray_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("stray_data_data_ok", 32'(data_data_ok), 32'd0);
        next_cycle();
        mem_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h0000_2000; mem_addr_ok = 1'b1; #1;
        chk("stray_then_data_addr_ok", 32'(data_addr_ok), 32'd1);
        next_cycle();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
        chk("stray_then_data_data_ok", 32'(data_data_ok), 32'd1);

        // Same-cycle conflict: data store goes first, inst right after data_ok.
        next_cycle();
        mem_data_ok = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_1000; data_wdata = 32'h1234_5678;
        mem_addr_ok = 1'b1; #1;
        chk("cf_mem_wr", 32'(mem_wr), 32'd1);
        chk("cf_mem_addr", mem_addr, 32'h0000_1000);
        chk("cf_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("cf_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("cf_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        next_cycle();
        data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0; #1;
        chk("cf_wd_mem_req", 32'(mem_req), 32'd0);
        chk("cf_wd_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        next_cycle();
        mem_data_ok = 1'b1; mem_addr_ok = 1'b1; #1;
        chk("cf_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("cf_no_b2b_mem_req", 32'(mem_req), 32'd0);
        chk("cf_no_b2b_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        next_cycle();
        mem_data_ok = 1'b0; #1;
        chk("cf_inst_addr_ok_next", 32'(inst_addr_ok), 32'd1);
        chk("cf_inst_mem_addr", mem_addr, 32'hBFC0_0004);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
        chk("cf_inst_data_ok", 32'(inst_data_ok), 32'd1);

        // Starvation guard with both requests held: data x4, inst, data x4, inst.
        for (int g = 0; g < 10; g++) begin
            logic exp_inst;
            exp_inst = (g == 4) || (g == 9);
            next_cycle();
            inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h0000_3000 + 32'(g);
            mem_addr_ok = 1'b1; mem_data_ok = 1'b0; #1;
            chk($sformatf("sv_g%0d_inst_addr_ok", g), 32'(inst_addr_ok), 32'(exp_inst));
            chk($sformatf("sv_g%0d_data_addr_ok", g), 32'(data_addr_ok), 32'(!exp_inst));
            chk($sformatf("sv_g%0d_mem_addr", g), mem_addr,
                exp_inst ? 32'hBFC0_0004 : 32'h0000_3000 + 32'(g));
            next_cycle();
            mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
            chk($sformatf("sv_g%0d_data_ok", g), {30'd0, inst_data_ok, data_data_ok},
                exp_inst ? 32'd2 : 32'd1);
        end

        // Address-phase stall on a data owner while inst rises.
        next_cycle();
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_4000;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; #1;
        chk("st_c0_mem_addr", mem_addr, 32'h0000_4000);
        chk("st_c0_data_addr_ok", 32'(data_addr_ok), 32'd0);
        for (int c = 1; c < 5; c++) begin
            next_cycle();
            inst_req = 1'b1; #1;
            chk($sformatf("st_c%0d_mem_addr", c), mem_addr, 32'h0000_4000);
            chk($sformatf("st_c%0d_mem_req", c), 32'(mem_req), 32'd1);
            chk($sformatf("st_c%0d_inst_addr_ok", c), 32'(inst_addr_ok), 32'd0);
        end
        next_cycle();
        mem_addr_ok = 1'b1; #1;
        chk("st_c5_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("st_c5_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        next_cycle();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
        chk("st_data_data_ok", 32'(data_data_ok), 32'd1);
        next_cycle();
        mem_data_ok = 1'b0; mem_addr_ok = 1'b1; #1;
        chk("st_inst_after", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
        chk("st_inst_data_ok", 32'(inst_data_ok), 32'd1);

        // Owner withdrawing its request in the address phase parks the bus.
        next_cycle();
        mem_data_ok = 1'b0; data_req = 1'b1; mem_addr_ok = 1'b0;
        next_cycle();
        data_req = 1'b0; mem_addr_ok = 1'b1; #1;
        chk("pv_mem_req", 32'(mem_req), 32'd0);
        chk("pv_data_addr_ok", 32'(data_addr_ok), 32'd0);
        next_cycle();
        data_req = 1'b1; #1;
        chk("pv_resume_addr_ok", 32'(data_addr_ok), 32'd1);
        next_cycle();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
        chk("pv_data_data_ok", 32'(data_data_ok), 32'd1);

        // Reset during WAIT_DATA drops the transaction.
        next_cycle();
        mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0100; mem_addr_ok = 1'b1; #1;
        chk("rm_grant", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
        resetn = 1'b0; #1;
        chk("rm_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rm_inst_rdata", inst_rdata, 32'd0);
        next_cycle();
        resetn = 1'b1; mem_data_ok = 1'b0;
        next_cycle();
        inst_req = 1'b1; mem_addr_ok = 1'b1; #1;
        chk("rm_fresh_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("rm_fresh_mem_addr", mem_addr, 32'hBFC0_0100);
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
        chk("rm_fresh_data_ok", 32'(inst_data_ok), 32'd1);
        chk("rm_fresh_rdata", inst_rdata, 32'hCAFE_F00D);
        next_cycle();
        mem_data_ok = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
